// File: rtl/profile_gen_mc_pkg.sv
// Shared constants and types for the multi-channel profile generator.
// Register map, STATUS bit layout and sweep FSM states.
package profile_gen_mc_pkg;

  localparam logic [3:0] R_STATUS = 4'd0;
  localparam logic [3:0] R_V      = 4'd1;
  localparam logic [3:0] R_A      = 4'd2;
  localparam logic [3:0] R_J      = 4'd3;
  localparam logic [3:0] R_TGT    = 4'd4;
  localparam logic [3:0] R_ABRT   = 4'd5;

  localparam int ST_W     = 6;
  localparam int ST_EN    = 0;
  localparam int ST_TV    = 1;
  localparam int ST_REACH = 2;
  localparam int ST_ABTD  = 3;
  localparam int ST_PEND  = 4;
  localparam int ST_ACT   = 5;

  localparam logic [ST_W-1:0] M_EN    = 6'h01;
  localparam logic [ST_W-1:0] M_TV    = 6'h02;
  localparam logic [ST_W-1:0] M_REACH = 6'h04;
  localparam logic [ST_W-1:0] M_ABTD  = 6'h08;
  localparam logic [ST_W-1:0] M_PEND  = 6'h10;
  localparam logic [ST_W-1:0] M_ACT   = 6'h20;

  localparam int SLOT_CYCLES = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WB
  } state_e;

endpackage

// File: rtl/profile_gen_mc_alu.sv
// Combinational single-channel update: normal jerk/accel
// integration, target-velocity clamp and abort deceleration.
module profile_gen_mc_alu
  import profile_gen_mc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [ST_W-1:0]  st_i,
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] abrt_i,
  output logic [ST_W-1:0]  st_o,
  output logic [WIDTH-1:0] v_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] j_o
);

  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] v_n;
  logic [WIDTH-1:0] v_abs;
  logic [WIDTH-1:0] v_dec;
  logic             ab_req;
  logic             hit;

  always_comb begin
    st_o   = st_i;
    v_o    = v_i;
    a_o    = a_i;
    j_o    = j_i;
    a_n    = a_i + j_i;
    v_n    = v_i + a_n;
    v_abs  = v_i[WIDTH-1] ? (~v_i + 1'b1) : v_i;
    v_dec  = v_i[WIDTH-1] ? (v_i + abrt_i) : (v_i - abrt_i);
    ab_req = st_i[ST_PEND] | st_i[ST_ACT];
    // direction of travel is taken from the updated acceleration
    hit = ($signed(a_n) > 0 && $signed(v_n) >= $signed(tgt_i))
       || ($signed(a_n) < 0 && $signed(v_n) <= $signed(tgt_i))
       || (a_n == '0 && v_n == tgt_i);
    priority case (1'b1)
      (ab_req && !st_i[ST_EN]): begin
        st_o[ST_PEND] = 1'b0;
        st_o[ST_ACT]  = 1'b0;
        st_o[ST_ABTD] = 1'b1;
      end
      (ab_req && v_abs <= abrt_i): begin
        v_o           = '0;
        a_o           = '0;
        j_o           = '0;
        st_o[ST_EN]   = 1'b0;
        st_o[ST_ABTD] = 1'b1;
        st_o[ST_PEND] = 1'b0;
        st_o[ST_ACT]  = 1'b0;
      end
      ab_req: begin
        v_o          = v_dec;
        a_o          = '0;
        j_o          = '0;
        st_o[ST_ACT] = 1'b1;
      end
      (!st_i[ST_EN]): begin
        st_o = st_i;
      end
      (st_i[ST_TV] && hit): begin
        v_o            = tgt_i;
        a_o            = '0;
        j_o            = '0;
        st_o[ST_REACH] = 1'b1;
      end
      default: begin
        v_o = v_n;
        a_o = a_n;
      end
    endcase
  end

endmodule

// File: rtl/profile_gen_mc.sv
// Multi-channel profile generator: one ALU time-shared over
// per-channel register files, swept once per acc_step.
module profile_gen_mc
  import profile_gen_mc_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int CH_BITS = 3,
  parameter int WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_step,
  input  logic [N_CH-1:0]       abort,
  input  logic [CH_BITS+3:0]    param_addr,
  input  logic [31:0]           param_in,
  input  logic                  param_write_hi,
  input  logic                  param_write_lo,
  output logic [WIDTH-1:0]      param_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [N_CH*WIDTH-1:0] speed
);

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(N_CH - 1);
  localparam logic [CH_BITS:0]   N_CH_W  = (CH_BITS + 1)'(N_CH);

  state_e             state_q, state_d;
  logic [CH_BITS-1:0] ch_q, ch_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic [WIDTH-1:0]   po_q, po_d;

  logic [ST_W-1:0]  st_q   [N_CH];
  logic [ST_W-1:0]  st_d   [N_CH];
  logic [WIDTH-1:0] v_q    [N_CH];
  logic [WIDTH-1:0] v_d    [N_CH];
  logic [WIDTH-1:0] a_q    [N_CH];
  logic [WIDTH-1:0] a_d    [N_CH];
  logic [WIDTH-1:0] j_q    [N_CH];
  logic [WIDTH-1:0] j_d    [N_CH];
  logic [WIDTH-1:0] tgt_q  [N_CH];
  logic [WIDTH-1:0] tgt_d  [N_CH];
  logic [WIDTH-1:0] abrt_q [N_CH];
  logic [WIDTH-1:0] abrt_d [N_CH];
  logic [WIDTH-1:0] spd_q  [N_CH];
  logic [WIDTH-1:0] spd_d  [N_CH];

  logic [ST_W-1:0]    alu_st;
  logic [WIDTH-1:0]   alu_v;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_j;
  logic [CH_BITS-1:0] h_ch;
  logic [3:0]         h_reg;
  logic               h_ok;
  logic               h_wr;
  logic [N_CH-1:0]    wb_sel;
  logic [N_CH-1:0]    hw_sel;

  function automatic logic [WIDTH-1:0] merge(
    input logic [WIDTH-1:0] old,
    input logic [31:0]      d,
    input logic             lo,
    input logic             hi
  );
    logic [WIDTH-1:0] r;
    r = old;
    if (lo) r[31:0] = d;
    if (hi) r[WIDTH-1:32] = d[WIDTH-33:0];
    return r;
  endfunction

  assign h_ch  = param_addr[CH_BITS+3:4];
  assign h_reg = param_addr[3:0];
  assign h_ok  = ({1'b0, h_ch} < N_CH_W);
  assign h_wr  = param_write_lo | param_write_hi;
  assign busy  = (state_q != S_IDLE);

  profile_gen_mc_alu #(.WIDTH(WIDTH)) u_alu (
    .st_i   (st_q[ch_q]),
    .v_i    (v_q[ch_q]),
    .a_i    (a_q[ch_q]),
    .j_i    (j_q[ch_q]),
    .tgt_i  (tgt_q[ch_q]),
    .abrt_i (abrt_q[ch_q]),
    .st_o   (alu_st),
    .v_o    (alu_v),
    .a_o    (alu_a),
    .j_o    (alu_j)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc_step) begin
          state_d = S_READ;
          ch_d    = '0;
        end
      end
      S_READ: state_d = S_WB;
      S_WB: begin
        if (ch_q == LAST_CH) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
          ch_d    = ch_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_sel = '0;
    hw_sel = '0;
    if (state_q == S_WB) wb_sel[ch_q] = 1'b1;
    if (h_ok && h_wr) hw_sel[h_ch] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      v_d[i]    = v_q[i];
      a_d[i]    = a_q[i];
      j_d[i]    = j_q[i];
      tgt_d[i]  = tgt_q[i];
      abrt_d[i] = abrt_q[i];
      spd_d[i]  = spd_q[i];
      if (wb_sel[i]) begin
        st_d[i] = alu_st;
        v_d[i]  = alu_v;
        a_d[i]  = alu_a;
        j_d[i]  = alu_j;
      end
      // host write overrides the sweep for the addressed register only
      if (hw_sel[i]) begin
        case (h_reg)
          R_STATUS: begin
            st_d[i][ST_REACH] = 1'b0;
            st_d[i][ST_ABTD]  = 1'b0;
            if (param_write_lo) begin
              st_d[i][ST_EN] = param_in[ST_EN];
              st_d[i][ST_TV] = param_in[ST_TV];
            end
          end
          R_V:    v_d[i]    = merge(v_q[i], param_in, param_write_lo, param_write_hi);
          R_A:    a_d[i]    = merge(a_q[i], param_in, param_write_lo, param_write_hi);
          R_J:    j_d[i]    = merge(j_q[i], param_in, param_write_lo, param_write_hi);
          R_TGT:  tgt_d[i]  = merge(tgt_q[i], param_in, param_write_lo, param_write_hi);
          R_ABRT: abrt_d[i] = merge(abrt_q[i], param_in, param_write_lo, param_write_hi);
          default: ;
        endcase
      end
      if (abort[i]) st_d[i][ST_PEND] = 1'b1;
      if (wb_sel[i] || (hw_sel[i] && h_reg == R_V)) spd_d[i] = v_d[i];
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (hw_sel[0] && h_reg == R_STATUS) ovr_d = 1'b0;
    if (acc_step && busy) ovr_d = 1'b1;
  end

  always_comb begin
    po_d = '0;
    if (h_ok) begin
      case (h_reg)
        R_STATUS: po_d = WIDTH'(st_q[h_ch]);
        R_V:      po_d = v_q[h_ch];
        R_A:      po_d = a_q[h_ch];
        R_J:      po_d = j_q[h_ch];
        R_TGT:    po_d = tgt_q[h_ch];
        R_ABRT:   po_d = abrt_q[h_ch];
        default:  po_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      po_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= '0;
        v_q[i]    <= '0;
        a_q[i]    <= '0;
        j_q[i]    <= '0;
        tgt_q[i]  <= '0;
        abrt_q[i] <= '0;
        spd_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      po_q    <= po_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= st_d[i];
        v_q[i]    <= v_d[i];
        a_q[i]    <= a_d[i];
        j_q[i]    <= j_d[i];
        tgt_q[i]  <= tgt_d[i];
        abrt_q[i] <= abrt_d[i];
        spd_q[i]  <= spd_d[i];
      end
    end
  end

  always_comb begin
    speed = '0;
    for (int i = 0; i < N_CH; i++) speed[i*WIDTH +: WIDTH] = spd_q[i];
  end

  assign done      = done_q;
  assign overrun   = ovr_q;
  assign param_out = po_q;

endmodule

// File: tb/tb_profile_gen_mc.sv
// Directed bench for profile_gen_mc: reset, sweep timing,
// target clamp, abort, overrun, host-vs-writeback, reset mid-sweep.
module tb_profile_gen_mc;
  import profile_gen_mc_pkg::*;

  localparam int NC = 8;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          acc_step;
  logic [NC-1:0] abort;
  logic [6:0]    param_addr;
  logic [31:0]   param_in;
  logic          param_write_hi;
  logic          param_write_lo;
  logic [W-1:0]  param_out;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [NC*W-1:0] speed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  profile_gen_mc #(.N_CH(NC), .CH_BITS(3), .WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .acc_step       (acc_step),
    .abort          (abort),
    .param_addr     (param_addr),
    .param_in       (param_in),
    .param_write_hi (param_write_hi),
    .param_write_lo (param_write_lo),
    .param_out      (param_out),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun),
    .speed          (speed)
  );

  task automatic host_write(input int ch, input logic [3:0] rg,
                            input logic [31:0] d, input logic lo,
                            input logic hi);
    @(negedge clk);
    param_addr     = {3'(ch), rg};
    param_in       = d;
    param_write_lo = lo;
    param_write_hi = hi;
    @(negedge clk);
    param_write_lo = 1'b0;
    param_write_hi = 1'b0;
  endtask

  task automatic wr64(input int ch, input logic [3:0] rg,
                      input logic [63:0] d);
    host_write(ch, rg, d[63:32], 1'b0, 1'b1);
    host_write(ch, rg, d[31:0], 1'b1, 1'b0);
  endtask

  task automatic rd(input int ch, input logic [3:0] rg,
                    output logic [63:0] val);
    @(negedge clk);
    param_addr = {3'(ch), rg};
    @(negedge clk);
    val = param_out;
  endtask

  task automatic run_sweep(input int ab_at, input int ov_at,
                           input int rs_at, input int hw_at,
                           output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    @(negedge clk);
    acc_step = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      acc_step       = 1'b0;
      abort          = '0;
      rst            = 1'b0;
      param_write_lo = 1'b0;
      if (done) ndone++;
      if (!busy) break;
      nbusy++;
      if (k == ab_at) abort[0] = 1'b1;
      if (k == ov_at) acc_step = 1'b1;
      if (k == rs_at) rst = 1'b1;
      if (k == hw_at) begin
        param_addr     = {3'd7, R_V};
        param_in       = 32'd5;
        param_write_lo = 1'b1;
      end
    end
  endtask

  task automatic step();
    int nb, nd;
    run_sweep(0, 0, 0, 0, nb, nd);
    n_cmp++;
    if (nb !== 16 || nd !== 1) begin
      n_bad++;
      $display("FAIL step_len busy=%0d done=%0d want 16/1", nb, nd);
    end
  endtask

  task automatic test_reset();
    logic [63:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, overrun} !== 3'b000 || speed !== '0) begin
      n_bad++;
      $display("FAIL reset_out b/d/o=%b%b%b speed_nz=%0d want 000/0",
               busy, done, overrun, speed != '0);
    end
    rst = 1'b0;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < 8; r++) begin
        rd(c, 4'(r), v);
        n_cmp++;
        if (v !== 64'd0) begin
          n_bad++;
          $display("FAIL reset_reg ch%0d r%0d got %h want 0", c, r, v);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int nb, nd;
    run_sweep(0, 0, 0, 0, nb, nd);
    n_cmp++;
    if (nb !== 16 || nd !== 1) begin
      n_bad++;
      $display("FAIL sweep_len busy=%0d done=%0d want 16/1", nb, nd);
    end
    n_cmp++;
    if (speed !== '0) begin
      n_bad++;
      $display("FAIL sweep_speed got nonzero want 0");
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_width got %b want 0", done);
    end
  endtask

  task automatic test_target();
    logic [63:0] v;
    int exp_v [5] = '{-230, -160, -90, -20, 40};
    wr64(0, R_V, -64'sd300);
    rd(0, R_V, v);
    n_cmp++;
    if (v !== 64'hFFFF_FFFF_FFFF_FED4) begin
      n_bad++;
      $display("FAIL sign_ext got %h want fffffffffffffed4", v);
    end
    wr64(0, R_A, 64'd70);
    wr64(0, R_TGT, 64'd40);
    host_write(0, R_STATUS, 32'h3, 1'b1, 1'b0);
    for (int s = 0; s < 5; s++) begin
      step();
      rd(0, R_V, v);
      n_cmp++;
      if (v !== 64'(exp_v[s])) begin
        n_bad++;
        $display("FAIL target_v step%0d got %0d want %0d",
                 s + 1, $signed(v), exp_v[s]);
      end
    end
    rd(0, R_A, v);
    n_cmp++;
    if (v !== 64'd0) begin
      n_bad++;
      $display("FAIL target_a got %0d want 0", $signed(v));
    end
    rd(0, R_STATUS, v);
    n_cmp++;
    if (v !== 64'h7) begin
      n_bad++;
      $display("FAIL target_st got %h want 7", v);
    end
    n_cmp++;
    if (speed[63:0] !== 64'd40) begin
      n_bad++;
      $display("FAIL target_spd got %0d want 40", $signed(speed[63:0]));
    end
    step();
    rd(0, R_V, v);
    n_cmp++;
    if (v !== 64'd40) begin
      n_bad++;
      $display("FAIL target_hold got %0d want 40", $signed(v));
    end
  endtask

  task automatic test_abort();
    logic [63:0] v;
    int nb, nd;
    host_write(0, R_STATUS, 32'h0, 1'b1, 1'b0);
    wr64(0, R_V, -64'sd160);
    wr64(0, R_A, 64'd70);
    wr64(0, R_ABRT, 64'd17);
    run_sweep(3, 0, 0, 0, nb, nd);
    rd(0, R_STATUS, v);
    n_cmp++;
    if (v !== 64'h10) begin
      n_bad++;
      $display("FAIL abort_pend got %h want 10", v);
    end
    rd(0, R_V, v);
    n_cmp++;
    if (v !== -64'sd160) begin
      n_bad++;
      $display("FAIL abort_v0 got %0d want -160", $signed(v));
    end
    host_write(0, R_STATUS, 32'h1, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      rd(0, R_V, v);
      n_cmp++;
      if (v !== 64'(-160 + 17 * k)) begin
        n_bad++;
        $display("FAIL abort_v step%0d got %0d want %0d",
                 k, $signed(v), -160 + 17 * k);
      end
      if (k == 1) begin
        rd(0, R_STATUS, v);
        n_cmp++;
        if (v !== 64'h31) begin
          n_bad++;
          $display("FAIL abort_act got %h want 31", v);
        end
        rd(0, R_A, v);
        n_cmp++;
        if (v !== 64'd0) begin
          n_bad++;
          $display("FAIL abort_a got %0d want 0", $signed(v));
        end
      end
    end
    step();
    rd(0, R_V, v);
    n_cmp++;
    if (v !== 64'd0) begin
      n_bad++;
      $display("FAIL abort_end_v got %0d want 0", $signed(v));
    end
    rd(0, R_STATUS, v);
    n_cmp++;
    if (v !== 64'h08) begin
      n_bad++;
      $display("FAIL abort_end_st got %h want 08", v);
    end
  endtask

  task automatic test_overrun();
    int nb, nd;
    run_sweep(0, 3, 0, 0, nb, nd);
    n_cmp++;
    if (nb !== 16 || nd !== 1 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set busy=%0d done=%0d ovr=%b want 16/1/1",
               nb, nd, overrun);
    end
    host_write(0, R_STATUS, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clr ovr=%b busy=%b want 0/0", overrun, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    int nb, nd;
    wr64(7, R_V, 64'd100);
    wr64(7, R_A, 64'd3);
    wr64(7, R_J, 64'd2);
    host_write(7, R_STATUS, 32'h1, 1'b1, 1'b0);
    run_sweep(0, 0, 0, 16, nb, nd);
    rd(7, R_V, v);
    n_cmp++;
    if (v !== 64'd5) begin
      n_bad++;
      $display("FAIL host_wins_v got %0d want 5", $signed(v));
    end
    rd(7, R_A, v);
    n_cmp++;
    if (v !== 64'd5) begin
      n_bad++;
      $display("FAIL host_wins_a got %0d want 5", $signed(v));
    end
    n_cmp++;
    if (speed[7*W +: W] !== 64'd5) begin
      n_bad++;
      $display("FAIL host_wins_spd got %0d want 5", $signed(speed[7*W +: W]));
    end
  endtask

  task automatic test_rst_mid();
    logic [63:0] v;
    int nb, nd;
    run_sweep(0, 0, 5, 0, nb, nd);
    n_cmp++;
    if (nb !== 5 || nd !== 0) begin
      n_bad++;
      $display("FAIL rst_mid busy=%0d done=%0d want 5/0", nb, nd);
    end
    rd(7, R_V, v);
    n_cmp++;
    if (v !== 64'd0 || speed !== '0) begin
      n_bad++;
      $display("FAIL rst_clear v7=%0d want 0", $signed(v));
    end
  endtask

  initial begin
    rst            = 1'b1;
    acc_step       = 1'b0;
    abort          = '0;
    param_addr     = '0;
    param_in       = '0;
    param_write_hi = 1'b0;
    param_write_lo = 1'b0;
    test_reset();
    test_sweep();
    test_target();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
